// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter granting up to two result broadcasts per
// cycle onto the two common-data-bus lanes (CDB, CDB2), with registered lanes.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   req[NUM_REQ]            unit i has a result pending
//   req_rob, req_data       per-unit tag/result, packed at [i*W +: W]
//   flush                   squash: no grants, lanes go idle, rr pointer to 0
//   grant[NUM_REQ]          combinational one-hot per winner (max two bits)
//   CDBiscast/RobNum/data   lane 0 (registered)
//   CDBiscast2/RobNum2/data2 lane 1 (registered)
//   stall_cnt, bcast_cnt    statistics, present only with CDB_STATS_EN
//
// Build option: define CDB_STATS_EN to add the saturating statistics counters.

module cdb_arbiter #(
    parameter int                 NUM_REQ     = 4,
    parameter int                 ROB_W       = 6,
    parameter int                 DATA_W      = 32,
    parameter logic [ROB_W-1:0]   INVALID_ROB = 6'b010000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ROB_W-1:0]  req_rob,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      flush,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      CDBiscast,
    output logic [ROB_W-1:0]          CDBrobNum,
    output logic [DATA_W-1:0]         CDBdata,
    output logic                      CDBiscast2,
    output logic [ROB_W-1:0]          CDBrobNum2,
    output logic [DATA_W-1:0]         CDBdata2
`ifdef CDB_STATS_EN
    ,
    output logic [15:0]               stall_cnt,
    output logic [15:0]               bcast_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   r_rr_ptr;
    logic               r_iscast;
    logic [ROB_W-1:0]   r_rob;
    logic [DATA_W-1:0]  r_data;
    logic               r_iscast2;
    logic [ROB_W-1:0]   r_rob2;
    logic [DATA_W-1:0]  r_data2;

    logic               w_found0;
    logic               w_found1;
    logic [PTR_W-1:0]   w_idx0;
    logic [PTR_W-1:0]   w_idx1;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [3:0]         w_req_cnt;

    // (p + k) mod NUM_REQ without relying on NUM_REQ being a power of two
    function automatic logic [PTR_W-1:0] wrap_add(
        input logic [PTR_W-1:0] p,
        input int               k
    );
        int s;
        s = int'(32'(p)) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[PTR_W-1:0];
    endfunction

    // Scan from rr_ptr upward: first hit takes lane 0, second takes lane 1
    always_comb begin
        w_found0  = 1'b0;
        w_found1  = 1'b0;
        w_idx0    = '0;
        w_idx1    = '0;
        w_idx     = '0;
        w_req_cnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx     = wrap_add(r_rr_ptr, k);
            w_req_cnt = w_req_cnt + 4'(req[k]);
            if (req[w_idx]) begin
                if (!w_found0) begin
                    w_found0 = 1'b1;
                    w_idx0   = w_idx;
                end else if (!w_found1) begin
                    w_found1 = 1'b1;
                    w_idx1   = w_idx;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (!flush) begin
            if (w_found0) grant[w_idx0] = 1'b1;
            if (w_found1) grant[w_idx1] = 1'b1;
        end
    end

    // Pointer moves just past the last winner; held when nothing is granted
    always_comb begin
        w_ptr_nxt = r_rr_ptr;
        if (w_found1)      w_ptr_nxt = wrap_add(w_idx1, 1);
        else if (w_found0) w_ptr_nxt = wrap_add(w_idx0, 1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_iscast  <= 1'b0;
            r_rob     <= INVALID_ROB;
            r_data    <= '0;
            r_iscast2 <= 1'b0;
            r_rob2    <= INVALID_ROB;
            r_data2   <= '0;
        end else if (flush) begin
            r_rr_ptr  <= '0;
            r_iscast  <= 1'b0;
            r_rob     <= INVALID_ROB;
            r_iscast2 <= 1'b0;
            r_rob2    <= INVALID_ROB;
        end else begin
            r_rr_ptr <= w_ptr_nxt;
            if (w_found0) begin
                r_iscast <= 1'b1;
                r_rob    <= req_rob[w_idx0*ROB_W +: ROB_W];
                r_data   <= req_data[w_idx0*DATA_W +: DATA_W];
            end else begin
                r_iscast <= 1'b0;
                r_rob    <= INVALID_ROB;
            end
            if (w_found1) begin
                r_iscast2 <= 1'b1;
                r_rob2    <= req_rob[w_idx1*ROB_W +: ROB_W];
                r_data2   <= req_data[w_idx1*DATA_W +: DATA_W];
            end else begin
                r_iscast2 <= 1'b0;
                r_rob2    <= INVALID_ROB;
            end
        end
    end

    assign CDBiscast  = r_iscast;
    assign CDBrobNum  = r_rob;
    assign CDBdata    = r_data;
    assign CDBiscast2 = r_iscast2;
    assign CDBrobNum2 = r_rob2;
    assign CDBdata2   = r_data2;

`ifdef CDB_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_bcast_cnt;
    logic [1:0]  w_ngrant;
    logic [16:0] w_bcast_sum;

    always_comb begin
        w_ngrant = '0;
        if (!flush) w_ngrant = 2'(w_found0) + 2'(w_found1);
        w_bcast_sum = {1'b0, r_bcast_cnt} + 17'(w_ngrant);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_bcast_cnt <= '0;
        end else begin
            if (!flush && w_req_cnt > 4'd2 && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            // Saturate rather than wrap when the sum overflows 16 bits
            r_bcast_cnt <= w_bcast_sum[16] ? 16'hFFFF : w_bcast_sum[15:0];
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign bcast_cnt = r_bcast_cnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter.
// Directed steps with hand-computed expectations; one summary line at the end.

module tb_cdb_arbiter;

    logic         clock;
    logic         reset;
    logic [3:0]   req;
    logic [23:0]  req_rob;
    logic [127:0] req_data;
    logic         flush;
    logic [3:0]   grant;
    logic         CDBiscast;
    logic [5:0]   CDBrobNum;
    logic [31:0]  CDBdata;
    logic         CDBiscast2;
    logic [5:0]   CDBrobNum2;
    logic [31:0]  CDBdata2;
`ifdef CDB_STATS_EN
    logic [15:0]  stall_cnt;
    logic [15:0]  bcast_cnt;
`endif

    int checks;
    int failures;

    cdb_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_rob    (req_rob),
        .req_data   (req_data),
        .flush      (flush),
        .grant      (grant),
        .CDBiscast  (CDBiscast),
        .CDBrobNum  (CDBrobNum),
        .CDBdata    (CDBdata),
        .CDBiscast2 (CDBiscast2),
        .CDBrobNum2 (CDBrobNum2),
        .CDBdata2   (CDBdata2)
`ifdef CDB_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .bcast_cnt  (bcast_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        req      = 4'b0000;
        req_rob  = '0;
        req_data = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // 1. reset state, idle request
        #1;
        chk("rst_grant",  32'(grant), 32'h0);
        chk("rst_v0",     32'(CDBiscast), 32'h0);
        chk("rst_v1",     32'(CDBiscast2), 32'h0);
        chk("rst_rob0",   32'(CDBrobNum), 32'h10);
        chk("rst_rob1",   32'(CDBrobNum2), 32'h10);
        chk("rst_data0",  CDBdata, 32'h0);
        cyc();
        chk("idle_v0",    32'(CDBiscast), 32'h0);
        chk("idle_rob0",  32'(CDBrobNum), 32'h10);

        // 2. single requester unit 1
        req      = 4'b0010;
        req_rob  = {6'd0, 6'd0, 6'd5, 6'd0};
        req_data = {32'd0, 32'd0, 32'd7, 32'd0};
        #1;
        chk("single_grant", 32'(grant), 32'h2);
        cyc();
        chk("single_v0",   32'(CDBiscast), 32'h1);
        chk("single_rob0", 32'(CDBrobNum), 32'd5);
        chk("single_dat0", CDBdata, 32'd7);
        chk("single_v1",   32'(CDBiscast2), 32'h0);
        chk("single_rob1", 32'(CDBrobNum2), 32'h10);
        req = 4'b0000;
        cyc();
        chk("pulse_v0",    32'(CDBiscast), 32'h0);
        chk("pulse_rob0",  32'(CDBrobNum), 32'h10);
        chk("hold_dat0",   CDBdata, 32'd7);

        // 5a. flush with all requesting (rr_ptr was 2, goes to 0)
        req      = 4'b1111;
        req_rob  = {6'd13, 6'd12, 6'd11, 6'd10};
        req_data = {32'd103, 32'd102, 32'd101, 32'd100};
        flush    = 1'b1;
        #1;
        chk("flush_grant", 32'(grant), 32'h0);
        cyc();
        chk("flush_v0",    32'(CDBiscast), 32'h0);
        chk("flush_v1",    32'(CDBiscast2), 32'h0);
        chk("flush_rob0",  32'(CDBrobNum), 32'h10);
        flush = 1'b0;

        // 3. all four held from rr_ptr=0: 0011, 1100, 0011
        #1;
        chk("all1_grant", 32'(grant), 32'h3);
        cyc();
        chk("all1_rob0",  32'(CDBrobNum), 32'd10);
        chk("all1_rob1",  32'(CDBrobNum2), 32'd11);
        chk("all1_dat0",  CDBdata, 32'd100);
        chk("all1_dat1",  CDBdata2, 32'd101);
        chk("all1_v1",    32'(CDBiscast2), 32'h1);
        chk("all2_grant", 32'(grant), 32'hC);
        cyc();
        chk("all2_rob0",  32'(CDBrobNum), 32'd12);
        chk("all2_rob1",  32'(CDBrobNum2), 32'd13);
        chk("all2_dat1",  CDBdata2, 32'd103);
        chk("all3_grant", 32'(grant), 32'h3);
        cyc();
        chk("all3_rob0",  32'(CDBrobNum), 32'd10);
        chk("all3_rob1",  32'(CDBrobNum2), 32'd11);

        // 4. wrap-around: unit 2 alone moves rr_ptr to 3, then 1001
        req = 4'b0100;
        #1;
        chk("adv_grant",  32'(grant), 32'h4);
        cyc();
        chk("adv_rob0",   32'(CDBrobNum), 32'd12);
        chk("adv_v1",     32'(CDBiscast2), 32'h0);
        req = 4'b1001;
        #1;
        chk("wrap_grant", 32'(grant), 32'h9);
        cyc();
        chk("wrap_rob0",  32'(CDBrobNum), 32'd13);
        chk("wrap_rob1",  32'(CDBrobNum2), 32'd10);
        // rr_ptr=1 now: unit 1 must take lane 0 ahead of unit 0
        req = 4'b0011;
        #1;
        chk("ptr1_grant", 32'(grant), 32'h3);
        cyc();
        chk("ptr1_rob0",  32'(CDBrobNum), 32'd11);
        chk("ptr1_rob1",  32'(CDBrobNum2), 32'd10);
        req = 4'b0000;

        // 5b. async reset mid-broadcast
        #1;
        reset = 1'b1;
        #1;
        chk("arst_v0",   32'(CDBiscast), 32'h0);
        chk("arst_v1",   32'(CDBiscast2), 32'h0);
        chk("arst_rob0", 32'(CDBrobNum), 32'h10);
        chk("arst_dat0", CDBdata, 32'h0);
        #1;
        reset = 1'b0;
`ifdef CDB_STATS_EN
        #1;
        chk("st_rst_stall", 32'(stall_cnt), 32'd0);
        chk("st_rst_bcast", 32'(bcast_cnt), 32'd0);
`endif

        // 6. req=0111 for three cycles from rr_ptr=0
        cyc();
        req = 4'b0111;
        #1;
        chk("r7a_grant", 32'(grant), 32'h3);
        cyc();
        chk("r7a_rob0",  32'(CDBrobNum), 32'd10);
        chk("r7a_rob1",  32'(CDBrobNum2), 32'd11);
        chk("r7b_grant", 32'(grant), 32'h5);
        cyc();
        chk("r7b_rob0",  32'(CDBrobNum), 32'd12);
        chk("r7b_rob1",  32'(CDBrobNum2), 32'd10);
        chk("r7c_grant", 32'(grant), 32'h6);
        cyc();
        chk("r7c_rob0",  32'(CDBrobNum), 32'd11);
        chk("r7c_rob1",  32'(CDBrobNum2), 32'd12);
        req = 4'b0000;
`ifdef CDB_STATS_EN
        chk("st_stall", 32'(stall_cnt), 32'd3);
        chk("st_bcast", 32'(bcast_cnt), 32'd6);
`endif
        cyc();
        chk("end_v0", 32'(CDBiscast), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
